// File: rtl/cubic_result_framer.sv
// cubic_result_framer
//   Output framer for the Horner cubic pipeline. Result beats go into a small
//   first-word-fall-through FIFO. Each stored entry carries a TLAST tag. The
//   tag is computed on the input side from a beat counter, so frames close
//   every FRAME_LEN beats, or earlier when the upstream raises s_tlast.
//
// Ports
//   clk       : clock, all logic on posedge
//   rst       : synchronous reset, active low
//   s_tdata   : upstream result payload
//   s_tvalid  : upstream beat valid
//   s_tlast   : upstream early end-of-frame
//   s_tready  : framer can accept a beat (registered state and rst only)
//   m_tdata   : head-of-FIFO payload, zero when empty
//   m_tvalid  : head-of-FIFO valid
//   m_tlast   : head beat closes a frame
//   m_tready  : sink ready
//   level     : FIFO occupancy, 0..DEPTH
//   frames    : frames completed at the output, wraps at 16 bits
module cubic_result_framer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  // Storage is not reset; each entry is {tag_last, data}.
  logic [DATA_W:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]   frames_q, frames_d;

  logic          push, pop, tag_last;
  logic [DATA_W:0] head;

  assign head     = mem_q[rd_ptr_q];

  // rst gates both handshakes so that nothing moves during a reset cycle,
  // even while the registered level still shows old contents.
  assign s_tready = rst & (level_q != FULL_LVL);
  assign m_tvalid = rst & (level_q != '0);
  assign m_tdata  = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tlast  = m_tvalid & head[DATA_W];

  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign tag_last = s_tlast | (beat_cnt_q == LAST_BEAT);

  assign level    = level_q;
  assign frames   = frames_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    beat_cnt_d = beat_cnt_q;
    frames_d   = frames_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      beat_cnt_d = tag_last ? '0 : beat_cnt_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (m_tlast) begin
        frames_d = frames_q + 16'd1;
      end
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_cnt_q <= '0;
      frames_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      beat_cnt_q <= beat_cnt_d;
      frames_q   <= frames_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tag_last, s_tdata};
    end
  end

endmodule

// File: tb/tb_cubic_result_framer.sv
// Bench for cubic_result_framer: directed scenarios followed by random traffic,
// all checked against a queue model of the framed stream.
module tb_cubic_result_framer;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [2:0]  level;
  logic [15:0] frames;

  always #5 clk = ~clk;

  cubic_result_framer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .level(level), .frames(frames)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: queue of {last, data} in delivery order, input-side beat count,
  // and completed-frame counter.
  logic [32:0] mq[$];
  int          mcnt = 0;
  logic [15:0] mframes = '0;
  bit          last_push;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit l,
                       input bit mr, input bit rv, input bit do_chk);
    bit push, pop, t;
    logic [32:0] head;
    @(negedge clk);
    rst = rv; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
    #1;
    head = (rv && mq.size() > 0) ? mq[0] : 33'h0;
    if (do_chk) begin
      chk("s_tready", {63'h0, s_tready}, {63'h0, (rv && mq.size() < DEPTH)});
      chk("m_tvalid", {63'h0, m_tvalid}, {63'h0, (rv && mq.size() > 0)});
      chk("m_tdata",  {32'h0, m_tdata},  {32'h0, head[31:0]});
      chk("m_tlast",  {63'h0, m_tlast},  {63'h0, head[32]});
      chk("level",    {61'h0, level},    64'(mq.size()));
      chk("frames",   {48'h0, frames},   {48'h0, mframes});
    end
    push = rv && v && (mq.size() < DEPTH);
    pop  = rv && (mq.size() > 0) && mr;
    @(posedge clk);
    if (!rv) begin
      mq.delete();
      mcnt = 0;
      mframes = '0;
    end else begin
      if (pop) begin
        if (mq[0][32]) mframes = mframes + 16'd1;
        void'(mq.pop_front());
      end
      if (push) begin
        t = l || (mcnt == FRAME_LEN - 1);
        mq.push_back({t, d});
        mcnt = t ? 0 : mcnt + 1;
      end
    end
    last_push = push;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit l, input bit mr);
    int tries = 0;
    do begin
      cycle(1'b1, d, l, mr, 1'b1, 1'b1);
      tries++;
    end while (!last_push && tries < 64);
    chk("push_timeout", {63'h0, last_push}, 64'h1);
  endtask

  task automatic drain();
    int tries = 0;
    while (mq.size() > 0 && tries < 64) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      tries++;
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("drain_level", {61'h0, level}, 64'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int idx;
    bit rv, v, mr, l;

    // 1: reset for 3 cycles (first cycle unchecked: DUT state unknown), release
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rel_s_tready", {63'h0, s_tready}, 64'h1);
    chk("rel_frames", {48'h0, frames}, 64'h0);

    // 2: 16 back-to-back beats, sink always ready
    for (int i = 0; i < 16; i++) send_beat(32'h3F800000 + i, 1'b0, 1'b1);
    drain();
    chk("two_frames", {48'h0, frames}, 64'h2);

    // 3: stalled sink, offer 6 beats into a 4-deep FIFO
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h40000000 + idx, 1'b0, 1'b0, 1'b1, 1'b1);
      if (last_push) idx++;
    end
    #2;
    chk("stall_level", {61'h0, level}, 64'h4);
    chk("stall_head", {32'h0, m_tdata}, 64'h40000000);
    chk("stall_ready", {63'h0, s_tready}, 64'h0);
    while (idx < 6) begin
      send_beat(32'h40000000 + idx, 1'b0, 1'b1);
      idx++;
    end
    drain();

    // 4: early s_tlast on 3rd beat, then regular 8-beat frame
    do_reset(2);
    for (int i = 0; i < 12; i++) send_beat(32'h50000000 + i, (i == 2), 1'b1);
    drain();

    // 5: full FIFO, push and pop offered together -> only pop
    for (int i = 0; i < 4; i++) send_beat(32'h60000000 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'h60000004, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    chk("full_pop_level", {61'h0, level}, 64'h3);
    chk("full_new_head", {32'h0, m_tdata}, 64'h60000001);
    for (int i = 4; i < 24; i++) send_beat(32'h60000000 + i, 1'b0, (i % 2) == 0);
    drain();

    // 6: reset mid-frame at level 3, then first frame ends on its 8th beat
    for (int i = 0; i < 3; i++) send_beat(32'h70000000 + i, 1'b0, 1'b0);
    #2;
    chk("pre_rst_level", {61'h0, level}, 64'h3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("post_rst_level", {61'h0, level}, 64'h0);
    for (int i = 0; i < 8; i++) send_beat(32'h71000000 + i, 1'b0, 1'b1);
    drain();
    chk("post_rst_frames", {48'h0, frames}, 64'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      l  = ($urandom_range(0, 15) == 0);
      cycle(v, $urandom, l, mr, rv, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
